echo_median_filter: RTL

- Sits between the ultrasonic `sensor` block and `set_reading`. It takes the free-running `echo_cycles` word and returns a de-glitched echo width.
- Samples `echo_cycles` once per fixed sample period and rejects out-of-range values.
- Keeps a sliding window of the last WIN accepted samples and publishes their median with a one-cycle valid strobe.
- `set_reading` consumes `filtered_cycles` in place of raw `echo_cycles`, so single-shot echo glitches never reach the displays or the history.

---
 rtl/heightsensor_pkg.sv | 25 ++
 rtl/median_sorter.sv | 41 ++++
 rtl/echo_median_filter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/heightsensor_pkg.sv
// Shared types and helpers for the ultrasonic height-sensor datapath.
package heightsensor_pkg;

    localparam int CLK_HZ = 12_000_000;
    localparam int ECHO_W = 32;

    typedef logic [ECHO_W-1:0] echo_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SORT,
        DONE
    } filt_state_t;

    // Zero means no echo was captured; anything above max is a timeout.
    function automatic logic echo_in_range(input echo_t v, input echo_t max_v);
        return (v != '0) && (v <= max_v);
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/median_sorter.sv
// WIN-entry odd-even transposition sorter; one compare-and-swap pass per step pulse.
module median_sorter
    import heightsensor_pkg::*;
#(
    parameter int WIN = 5
) (
    input  logic  clk,
    input  logic  load_i,
    input  logic  step_i,
    input  logic  parity_i,
    input  echo_t win_i [WIN],
    output echo_t mid_o
);

    echo_t sort_q [WIN];
    echo_t sort_d [WIN];

    // Pairs within a pass are disjoint, so every swap reads the registered values.
    always_comb begin
        sort_d = sort_q;
        if (load_i) begin
            sort_d = win_i;
        end else if (step_i) begin
            for (int i = 0; i < WIN - 1; i++) begin
                if (((i % 2) == 1) == parity_i) begin
                    if (sort_q[i] > sort_q[i+1]) begin
                        sort_d[i]   = sort_q[i+1];
                        sort_d[i+1] = sort_q[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        sort_q <= sort_d;
    end

    assign mid_o = sort_q[WIN/2];

endmodule

// File: rtl/echo_median_filter.sv
// Periodic echo sampler with range rejection and a sliding-window median output.
module echo_median_filter
    import heightsensor_pkg::*;
#(
    parameter int SAMPLE_PERIOD = 720000,
    parameter int WIN           = 5,
    parameter int MAX_CYCLES    = 300000,
    parameter int STALE_LIMIT   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] echo_cycles,
    output logic [31:0] filtered_cycles,
    output logic        filt_valid,
    output logic        busy,
    output logic        stale,
    output logic [7:0]  reject_cnt
);

    localparam int PER_W  = $clog2(SAMPLE_PERIOD);
    localparam int PTR_W  = $clog2(WIN);
    localparam int FILL_W = $clog2(WIN + 1);

    logic [PER_W-1:0]  per_q, per_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [FILL_W-1:0] fill_q, fill_d, fill_inc;
    logic [7:0]        cons_q, cons_d;
    logic [7:0]        rej_q, rej_d;
    logic [PTR_W-1:0]  pass_q, pass_d;
    filt_state_t       state_q, state_d;
    echo_t             win_q [WIN];
    echo_t             win_d [WIN];
    echo_t             filt_q, filt_d;
    echo_t             mid;
    logic              tick, in_range, wr_en;
    logic              sort_load, sort_step;

    assign tick     = (per_q == PER_W'(SAMPLE_PERIOD - 1));
    assign in_range = echo_in_range(echo_cycles, echo_t'(MAX_CYCLES));
    // The window is frozen while the sorter owns a snapshot of it.
    assign wr_en    = tick && in_range && (state_q == IDLE || state_q == DONE);
    assign fill_inc = (fill_q == FILL_W'(WIN)) ? fill_q : fill_q + 1'b1;

    always_comb begin
        per_d    = tick ? '0 : per_q + 1'b1;
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        win_d    = win_q;
        cons_d   = cons_q;
        rej_d    = rej_q;
        if (wr_en) begin
            win_d[wr_ptr_q] = echo_cycles;
            wr_ptr_d        = (wr_ptr_q == PTR_W'(WIN - 1)) ? '0 : wr_ptr_q + 1'b1;
            fill_d          = fill_inc;
        end
        if (tick && in_range) begin
            cons_d = '0;
        end else if (tick) begin
            cons_d = sat_inc8(cons_q);
            rej_d  = sat_inc8(rej_q);
        end
    end

    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        filt_d  = filt_q;
        case (state_q)
            IDLE: begin
                if (wr_en && fill_inc == FILL_W'(WIN)) state_d = LOAD;
            end
            LOAD: begin
                state_d = SORT;
                pass_d  = '0;
            end
            SORT: begin
                if (pass_q == PTR_W'(WIN - 1)) state_d = DONE;
                else                           pass_d  = pass_q + 1'b1;
            end
            DONE: begin
                filt_d  = mid;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            per_q    <= '0;
            wr_ptr_q <= '0;
            fill_q   <= '0;
            cons_q   <= '0;
            rej_q    <= '0;
            pass_q   <= '0;
            state_q  <= IDLE;
            filt_q   <= '0;
            win_q    <= '{default: '0};
        end else begin
            per_q    <= per_d;
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
            cons_q   <= cons_d;
            rej_q    <= rej_d;
            pass_q   <= pass_d;
            state_q  <= state_d;
            filt_q   <= filt_d;
            win_q    <= win_d;
        end
    end

    assign sort_load = (state_q == LOAD);
    assign sort_step = (state_q == SORT);

    median_sorter #(
        .WIN(WIN)
    ) u_sorter (
        .clk      (clk),
        .load_i   (sort_load),
        .step_i   (sort_step),
        .parity_i (pass_q[0]),
        .win_i    (win_q),
        .mid_o    (mid)
    );

    // The sorted median is already settled in DONE, so it is shown in the strobe cycle.
    assign filt_valid      = (state_q == DONE);
    assign filtered_cycles = filt_valid ? mid : filt_q;
    assign busy            = sort_load || sort_step;
    assign stale           = (cons_q >= 8'(STALE_LIMIT));
    assign reject_cnt      = rej_q;

endmodule
